// File: rtl/instr_encoder_if.sv
// Operation-in / encoded-word-out bus of the instruction encoder.
// The master side issues operations and consumes words; the slave side is the encoder.
interface instr_encoder_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic [4:0]       in_rs;
   logic [4:0]       in_rt;
   logic [4:0]       in_rd;
   logic [15:0]      in_imm;
   logic [25:0]      in_target;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [31:0]      out_addr;
   logic [CNT_W-1:0] out_count;
   logic             err;

   modport master (
      output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, out_count, err
   );

   modport slave (
      input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
      output in_ready, out_valid, out_instr, out_addr, out_count, err
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes abstract operations into MIPS words behind a one-deep registered output stage.
// Macro ENC_ILLEGAL_TRAP_EN: ops 10-15 raise a sticky err instead of emitting a NOP.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int          CNT_W     = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           restart,
   instr_encoder_if.slave bus
);
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_ORI = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_SW  = 4'd5;
   localparam logic [3:0] OP_BEQ = 4'd6;
   localparam logic [3:0] OP_LUI = 4'd7;
   localparam logic [3:0] OP_JAL = 4'd8;
   localparam logic [3:0] OP_JR  = 4'd9;

   localparam logic [5:0] OPC_ORI = 6'b001101;
   localparam logic [5:0] OPC_LW  = 6'b100011;
   localparam logic [5:0] OPC_SW  = 6'b101011;
   localparam logic [5:0] OPC_BEQ = 6'b000100;
   localparam logic [5:0] OPC_LUI = 6'b001111;
   localparam logic [5:0] OPC_JAL = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   logic             valid_reg;
   logic [31:0]      instr_reg;
   logic [31:0]      addr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             err_reg;
   logic [31:0]      word_next;
   logic             in_hs;
   logic             out_hs;
   logic             load;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {6'b000000, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   // Illegal codes fall through to the all-zero word, which is also the NOP encoding.
   always_comb begin
      word_next = 32'h0000_0000;
      case (bus.in_op)
         OP_NOP:  word_next = 32'h0000_0000;
         OP_ADD:  word_next = r_word(bus.in_rs, bus.in_rt, bus.in_rd, FN_ADD);
         OP_SUB:  word_next = r_word(bus.in_rs, bus.in_rt, bus.in_rd, FN_SUB);
         OP_ORI:  word_next = i_word(OPC_ORI, bus.in_rs, bus.in_rt, bus.in_imm);
         OP_LW:   word_next = i_word(OPC_LW, bus.in_rs, bus.in_rt, bus.in_imm);
         OP_SW:   word_next = i_word(OPC_SW, bus.in_rs, bus.in_rt, bus.in_imm);
         OP_BEQ:  word_next = i_word(OPC_BEQ, bus.in_rs, bus.in_rt, bus.in_imm);
         OP_LUI:  word_next = i_word(OPC_LUI, 5'd0, bus.in_rt, bus.in_imm);
         OP_JAL:  word_next = {OPC_JAL, bus.in_target};
         OP_JR:   word_next = r_word(bus.in_rs, 5'd0, 5'd0, FN_JR);
         default: word_next = 32'h0000_0000;
      endcase
   end

   assign bus.in_ready = reset && !restart && (!valid_reg || bus.out_ready);
   assign in_hs        = bus.in_valid && bus.in_ready;
   assign out_hs       = valid_reg && bus.out_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
   logic illegal;
   assign illegal = (bus.in_op > OP_JR);
   // A trapped op is consumed but must not disturb the output stage.
   assign load    = in_hs && !illegal;

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_reg <= 1'b0;
      end else if (in_hs && illegal) begin
         err_reg <= 1'b1;
      end
   end
`else
   assign load    = in_hs;
   assign err_reg = 1'b0;
`endif

   // Retire and load may both happen on one edge, so a new word replaces the old one with no bubble.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_reg <= 1'b0;
         instr_reg <= 32'h0000_0000;
         addr_reg  <= BASE_ADDR;
         count_reg <= '0;
      end else if (restart) begin
         valid_reg <= 1'b0;
         addr_reg  <= BASE_ADDR;
         count_reg <= '0;
      end else begin
         if (out_hs) begin
            addr_reg  <= addr_reg + 32'd4;
            count_reg <= count_reg + CNT_W'(1);
         end
         if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= word_next;
         end else if (out_hs) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign bus.out_valid = valid_reg;
   assign bus.out_instr = instr_reg;
   assign bus.out_addr  = addr_reg;
   assign bus.out_count = count_reg;
   assign bus.err       = err_reg;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words, a monitor pops them on retire.
// Build with ENC_ILLEGAL_TRAP_EN defined to exercise the illegal-op trap.
`timescale 1ns/1ps
module tb_instr_encoder;
   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam int          CNT_W = 16;
`ifdef ENC_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic restart = 1'b0;

   instr_encoder_if #(.CNT_W(CNT_W)) bus ();

   instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   bit          m_valid = 1'b0;
   bit          m_err = 1'b0;
   int unsigned push_idx = 0;
   int unsigned retired = 0;
   bit          post_clr = 1'b0;
   bit          post_rst = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference encoding straight from the instruction formats (decimal opcodes/functs).
   function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm, input logic [25:0] tgt);
      case (op)
         4'd1:    return {6'd0, rs, rt, rd, 5'd0, 6'd32};
         4'd2:    return {6'd0, rs, rt, rd, 5'd0, 6'd34};
         4'd3:    return {6'd13, rs, rt, imm};
         4'd4:    return {6'd35, rs, rt, imm};
         4'd5:    return {6'd43, rs, rt, imm};
         4'd6:    return {6'd4, rs, rt, imm};
         4'd7:    return {6'd15, 5'd0, rt, imm};
         4'd8:    return {6'd3, tgt};
         4'd9:    return {6'd0, rs, 15'd0, 6'd8};
         default: return 32'd0;
      endcase
   endfunction

   // One clock: drive inputs after the edge, predict readiness at the falling edge, push accepted words.
   task automatic cycle(input bit rst_n, input bit rs_t, input bit iv, input logic [3:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tgt, input bit ordy,
                        input bit use_exp, input logic [31:0] exp_word);
      bit   exp_ready;
      bit   acc;
      bit   ill;
      exp_t e;
      @(posedge clk);
      #1;
      reset         = rst_n;
      restart       = rs_t;
      bus.in_valid  = iv;
      bus.in_op     = op;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_imm    = imm;
      bus.in_target = tgt;
      bus.out_ready = ordy;
      @(negedge clk);
      exp_ready = rst_n && !rs_t && (!m_valid || ordy);
      check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
      check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
      check("err", {63'd0, bus.err}, {63'd0, m_err});
      ill = (op >= 4'd10);
      acc = iv && exp_ready;
      if (!rst_n) begin
         m_valid  = 1'b0;
         m_err    = 1'b0;
         push_idx = 0;
      end else if (rs_t) begin
         m_valid  = 1'b0;
         push_idx = 0;
      end else begin
         if (acc && TRAP && ill) m_err = 1'b1;
         if (acc && !(TRAP && ill)) begin
            e.instr = use_exp ? exp_word : ref_word(op, rs, rt, rd, imm, tgt);
            e.addr  = BASE + 32'(4 * push_idx);
            sb.push_back(e);
            push_idx++;
            m_valid = 1'b1;
         end else if (m_valid && ordy) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] exp_word);
      cycle(1'b1, 1'b0, 1'b1, op, rs, rt, rd, imm, tgt, 1'b1, 1'b1, exp_word);
   endtask

   task automatic idle(input bit ordy, input bit rs_t);
      cycle(1'b1, rs_t, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, ordy, 1'b0, 32'd0);
   endtask

   // Monitor: compares every retired word and the clear state after reset/restart.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (post_clr) begin
            check("clr_valid", {63'd0, bus.out_valid}, 64'd0);
            check("clr_addr", {32'd0, bus.out_addr}, {32'd0, BASE});
            check("clr_count", {48'd0, bus.out_count}, 64'd0);
            if (post_rst) check("rst_instr", {32'd0, bus.out_instr}, 64'd0);
            post_clr = 1'b0;
            post_rst = 1'b0;
         end
         if (!reset || restart) begin
            sb.delete();
            retired  = 0;
            post_clr = 1'b1;
            post_rst = !reset;
         end else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_word: got %h at %h expected no word", bus.out_instr, bus.out_addr);
            end else begin
               e = sb.pop_front();
               $display("[TB] word addr=%h instr=%h count=%0d", bus.out_addr, bus.out_instr, bus.out_count);
               check("out_instr", {32'd0, bus.out_instr}, {32'd0, e.instr});
               check("out_addr", {32'd0, bus.out_addr}, {32'd0, e.addr});
               check("out_count", {48'd0, bus.out_count}, {48'd0, retired[CNT_W-1:0]});
            end
            retired++;
         end
      end
   end

   initial begin : stimulus
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'd0;
      bus.in_rs     = 5'd0;
      bus.in_rt     = 5'd0;
      bus.in_rd     = 5'd0;
      bus.in_imm    = 16'd0;
      bus.in_target = 26'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 1'b0, 32'd0);

      // Directed encodings; unused fields carry junk that must be ignored.
      issue(4'd1, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h3FF_FFFF, 32'h0022_1820);
      issue(4'd3, 5'd0, 5'd8, 5'd31, 16'h1234, 26'h155_5555, 32'h3408_1234);
      issue(4'd7, 5'd5, 5'd1, 5'd9, 16'hFFFF, 26'h0, 32'h3C01_FFFF);
      issue(4'd8, 5'd7, 5'd7, 5'd7, 16'h7777, 26'h000_0C03, 32'h0C00_0C03);
      issue(4'd9, 5'd31, 5'd7, 5'd5, 16'hAAAA, 26'h0, 32'h03E0_0008);
      issue(4'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022_FFFF);
      issue(4'd5, 5'd0, 5'd2, 5'd3, 16'h0004, 26'h0, 32'hAC02_0004);
      issue(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h0085_3022);
      issue(4'd4, 5'd3, 5'd9, 5'd1, 16'h0010, 26'h0, 32'h8C69_0010);
      issue(4'd0, 5'd17, 5'd9, 5'd4, 16'h5A5A, 26'h123_4567, 32'h0000_0000);
      issue(4'd12, 5'd3, 5'd3, 5'd3, 16'h3333, 26'h0, 32'h0000_0000);
      idle(1'b1, 1'b0);

      // Backpressure: word held for three cycles while a new op waits, then retire+load together.
      issue(4'd1, 5'd10, 5'd11, 5'd12, 16'd0, 26'd0, 32'h014B_6020);
      repeat (3) cycle(1'b1, 1'b0, 1'b1, 4'd3, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'd0, 1'b0, 1'b1, 32'h3422_00FF);
      cycle(1'b1, 1'b0, 1'b1, 4'd3, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'd0, 1'b1, 1'b1, 32'h3422_00FF);
      idle(1'b1, 1'b0);

      // Restart with five words retired and one held; the op offered alongside is refused.
      idle(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) issue(4'd3, 5'd0, 5'(i), 5'd0, 16'(i), 26'd0, {16'h3400 | 16'(i), 16'(i)});
      cycle(1'b1, 1'b1, 1'b1, 4'd1, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 1'b1, 1'b0, 32'd0);
      idle(1'b1, 1'b0);

      // Random traffic with occasional restart and reset.
      for (int n = 0; n < 4000; n++) begin
         cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
               16'($urandom), 26'($urandom), ($urandom_range(0, 2) != 0), 1'b0, 32'd0);
      end

      repeat (4) idle(1'b1, 1'b0);
      @(negedge clk);
      check("drain", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Instruction encoder feeding the single-cycle datapath's instruction memory with legal MIPS words, for self-checking program loads.
- It is the producer side of the opcode/funct field protocol that the Control decoder consumes.
- Accepts abstract operations (mnemonic code plus register and immediate fields) over a valid/ready handshake.
- Emits encoded 32-bit words with their instruction-memory byte address through a one-deep registered output stage with backpressure.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address assigned to the first emitted word and restored by restart.
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- restart  input  1  synchronous soft clear: drops the held word and reloads the address.
- in_valid  input  1  operation present.
- in_ready  output  1  encoder can accept an operation this cycle.
- in_op  input  4  0 NOP, 1 ADD, 2 SUB, 3 ORI, 4 LW, 5 SW, 6 BEQ, 7 LUI, 8 JAL, 9 JR, 10-15 illegal.
- in_rs  input  5  rs field.
- in_rt  input  5  rt field.
- in_rd  input  5  rd field.
- in_imm  input  16  immediate / offset field.
- in_target  input  26  jump target field.
- out_valid  output  1  encoded word held.
- out_ready  input  1  consumer accepts the held word.
- out_instr  output  32  encoded instruction.
- out_addr  output  32  byte address of out_instr.
- out_count  output  CNT_W  number of words accepted by the consumer since reset/restart.
- err  output  1  sticky illegal-op flag (only with the optional feature).

Behaviour:
- Reset (reset==0 at posedge): out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_count=0, err=0.
- in_ready = reset && !restart && (!out_valid || out_ready). Input handshake: in_valid && in_ready.
- On input handshake: out_instr is loaded with the encoding and out_valid is 1 at the next edge. Latency is 1 cycle, and full throughput is 1 word/cycle while out_ready stays high.
- R-type encoding is {6'b0, rs, rt, rd, 5'b0, funct}:
  - ADD: funct 100000.
  - SUB: funct 100010.
  - JR: funct 001000 with rt = rd = 0 forced.
- I-type encoding is {op, rs, rt, imm}:
  - ORI: op 001101.
  - LW: op 100011.
  - SW: op 101011.
  - BEQ: op 000100.
  - LUI: op 001111 with rs = 0 forced.
- J-type encoding is {op, target}:
  - JAL: op 000011.
- NOP encodes as 32'h0000_0000.
- Fields not used by the encoding are ignored; no field is sign-extended or checked.
- Output handshake is out_valid && out_ready. On it:
  - out_addr += 4, wrapping modulo 2^32.
  - out_count += 1, wrapping modulo 2^CNT_W.
- If no new input is accepted in the same cycle as an output handshake, out_valid becomes 0.
- Simultaneous output and input handshake: the held word retires and the new word loads in the same edge, with no bubble.
- While out_valid && !out_ready: out_instr and out_addr hold stable, and in_ready=0.
- restart=1 at posedge:
  - out_valid=0, out_addr=BASE_ADDR, out_count=0.
  - err is preserved.
  - Any input presented that cycle is not accepted.
  - A pending output handshake in the same cycle is discarded; the count does not increment.
- Reset has priority over restart. A reset arriving mid-stream discards the held word.

Optional Feature:
- Macro ENC_ILLEGAL_TRAP_EN.
- Defined:
  - in_op 10-15 is accepted; no word is produced and out_valid is unchanged by it.
  - err is set to 1 and stays 1 until reset.
- Undefined:
  - in_op 10-15 encodes as NOP 32'h0000_0000 and is emitted normally.
  - err is tied to 0.

Test Plan:
- After reset: ADD rs=1 rt=2 rd=3 with out_ready=1 -> next cycle out_instr=32'h00221820, out_addr=32'h3000; after the handshake out_count=1.
- Back-to-back ORI rs=0 rt=8 imm=16'h1234, then LUI rs=5 rt=1 imm=16'hFFFF, out_ready=1:
  - out_instr = 32'h34081234 at addr 32'h3000.
  - then out_instr = 32'h3C01FFFF at addr 32'h3004; the rs field is forced to 0.
  - in_ready stays 1 throughout.
- JAL target=26'h0000C03 -> 32'h0C000C03. JR rs=31 rt=7 -> 32'h03E00008. BEQ rs=1 rt=2 imm=16'hFFFF -> 32'h1022FFFF. SW rs=0 rt=2 imm=4 -> 32'hAC020004.
- Backpressure: hold out_ready=0 for 3 cycles with a word held -> in_ready=0, out_instr/out_addr stable; releasing out_ready with in_valid=1 -> retire and load in the same edge.
- Restart asserted with out_valid=1, out_ready=1, out_count=5 -> next cycle out_valid=0, out_addr=32'h3000, out_count=0, and the input offered that cycle is not taken.
- in_op=12:
  - With ENC_ILLEGAL_TRAP_EN: err=1 and no word is emitted; err persists across restart and clears only on reset.
  - Without it: 32'h00000000 is emitted and err=0.
